// File: rtl/axi_aw_arbiter_wsched.sv
// ---------------------------------------------------------------------------
// axi_aw_arbiter_wsched
//
// Purpose:
//   Shares one slave-side AW channel among N_TARG_PORT address decoders.
//   The arbiter is round-robin, and a grant stays locked until the AW
//   handshake completes. Each accepted AW records its source index in a
//   W-order FIFO. The W mux reads the head of that FIFO to route write data
//   in AW order, and pops the entry on the last beat of the burst.
//
// Optional feature (macro AW_WSCHED_BYPASS_EN):
//   When the FIFO is empty, an AW handshake is presented on wsel_o and
//   wsel_valid_o in the same cycle. If wsel_pop_i is also high in that
//   cycle, the entry is consumed directly and is never written into the
//   FIFO. When the macro is undefined, wsel_valid_o rises only in the cycle
//   after the push.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   awvalid_i     per-requester AW valid            [N_TARG_PORT]
//   awdata_i      per-requester AW payload, packed  [N_TARG_PORT*AW_WIDTH]
//   awready_o     per-requester AW ready (one-hot or zero)
//   awvalid_o     AW valid toward slave
//   awdata_o      payload of granted requester
//   awready_i     AW ready from slave
//   wsel_o        source index for the current W burst (FIFO head)
//   wsel_valid_o  W source available
//   wsel_pop_i    last W beat of current burst accepted
// ---------------------------------------------------------------------------
module axi_aw_arbiter_wsched #(
    parameter int N_TARG_PORT    = 8,
    parameter int LOG_N_TARG     = 3,
    parameter int AW_WIDTH       = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int LOG_FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_TARG_PORT-1:0]          awvalid_i,
    input  logic [N_TARG_PORT*AW_WIDTH-1:0] awdata_i,
    output logic [N_TARG_PORT-1:0]          awready_o,
    output logic                            awvalid_o,
    output logic [AW_WIDTH-1:0]             awdata_o,
    input  logic                            awready_i,
    output logic [LOG_N_TARG-1:0]           wsel_o,
    output logic                            wsel_valid_o,
    input  logic                            wsel_pop_i
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [LOG_N_TARG:0]     N_TARG_W   = (LOG_N_TARG+1)'(N_TARG_PORT);
    localparam logic [LOG_N_TARG-1:0]   LAST_IDX   = LOG_N_TARG'(N_TARG_PORT - 1);
    localparam logic [LOG_FIFO_DEPTH:0] FIFO_FULL_W = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [LOG_N_TARG-1:0]     rr_ptr_r;
    logic [LOG_N_TARG-1:0]     locked_idx_r;
    logic [LOG_N_TARG-1:0]     winner_s;
    logic [LOG_N_TARG-1:0]     grant_s;
    logic                      any_req_s;
    logic                      awvalid_s;
    logic                      hs_s;
    logic [AW_WIDTH-1:0]       awdata_s;

    logic [LOG_N_TARG-1:0]     mem_r [FIFO_DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] rd_ptr_r;
    logic [LOG_FIFO_DEPTH-1:0] wr_ptr_r;
    logic [LOG_FIFO_DEPTH:0]   count_r;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      bypass_s;
    logic                      bypass_take_s;
    logic                      push_s;
    logic                      pop_s;

    assign any_req_s    = |awvalid_i;
    assign fifo_full_s  = (count_r == FIFO_FULL_W);
    assign fifo_empty_s = (count_r == {(LOG_FIFO_DEPTH+1){1'b0}});

    // Round-robin search: first requester at or after rr_ptr_r, wrapping.
    always_comb begin
        logic [LOG_N_TARG:0] sum_v;
        logic                found_v;
        winner_s = rr_ptr_r;
        found_v  = 1'b0;
        sum_v    = {(LOG_N_TARG+1){1'b0}};
        for (int i = 0; i < N_TARG_PORT; i++) begin
            sum_v = {1'b0, rr_ptr_r} + (LOG_N_TARG+1)'(i);
            if (sum_v >= N_TARG_W) begin
                sum_v = sum_v - N_TARG_W;
            end else begin
                sum_v = sum_v;
            end
            if (!found_v && awvalid_i[sum_v[LOG_N_TARG-1:0]]) begin
                winner_s = sum_v[LOG_N_TARG-1:0];
                found_v  = 1'b1;
            end else begin
                found_v  = found_v;
            end
        end
    end

    // Grant FSM: next state, selected source and slave-side valid.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = winner_s;
        awvalid_s   = 1'b0;
        case (state_r)
            ST_ARB: begin
                grant_s   = winner_s;
                awvalid_s = any_req_s & ~fifo_full_s;
                if (awvalid_s && !awready_i) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_HOLD: begin
                // Locked requester must keep its valid high until accepted.
                grant_s   = locked_idx_r;
                awvalid_s = 1'b1;
                if (awready_i) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
                grant_s     = winner_s;
                awvalid_s   = 1'b0;
            end
        endcase
    end

    // Payload mux for the granted requester.
    always_comb begin
        awdata_s = {AW_WIDTH{1'b0}};
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (grant_s == LOG_N_TARG'(i)) begin
                awdata_s = awdata_i[i*AW_WIDTH +: AW_WIDTH];
            end else begin
                awdata_s = awdata_s;
            end
        end
    end

    assign awvalid_o = awvalid_s & ~rst;
    assign hs_s      = awvalid_o & awready_i;
    assign awdata_o  = awdata_s;

    // One-hot ready toward the granted requester, only when the handshake occurs.
    always_comb begin
        awready_o = {N_TARG_PORT{1'b0}};
        if (hs_s) begin
            awready_o[grant_s] = 1'b1;
        end else begin
            awready_o = {N_TARG_PORT{1'b0}};
        end
    end

`ifdef AW_WSCHED_BYPASS_EN
    assign bypass_s      = hs_s & fifo_empty_s;
    assign bypass_take_s = bypass_s & wsel_pop_i;
`else
    assign bypass_s      = 1'b0;
    assign bypass_take_s = 1'b0;
`endif

    // A bypassed entry that is consumed in the same cycle never enters the FIFO.
    assign push_s = hs_s & ~bypass_take_s;
    // A pop frees a slot for the next cycle only; a push at full is blocked upstream.
    assign pop_s  = wsel_pop_i & ~fifo_empty_s;

    assign wsel_valid_o = ~rst & (~fifo_empty_s | bypass_s);
    assign wsel_o       = bypass_s ? grant_s : mem_r[rd_ptr_r];

    // State, round-robin pointer, lock index and W-order FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= {LOG_N_TARG{1'b0}};
            locked_idx_r <= {LOG_N_TARG{1'b0}};
            rd_ptr_r     <= {LOG_FIFO_DEPTH{1'b0}};
            wr_ptr_r     <= {LOG_FIFO_DEPTH{1'b0}};
            count_r      <= {(LOG_FIFO_DEPTH+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {LOG_N_TARG{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_ARB && state_nxt_s == ST_HOLD) begin
                locked_idx_r <= winner_s;
            end else begin
                locked_idx_r <= locked_idx_r;
            end
            if (hs_s) begin
                rr_ptr_r <= (grant_s == LAST_IDX) ? {LOG_N_TARG{1'b0}} : grant_s + 1'b1;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= grant_s;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_aw_arbiter_wsched.sv
// ---------------------------------------------------------------------------
// Testbench for axi_aw_arbiter_wsched.
// It runs a directed sequence first and then a randomized phase. Each cycle,
// every DUT output is compared against a reference model. The model is built
// from a pointer, a lock flag and a queue holding the W order.
// ---------------------------------------------------------------------------
module tb_axi_aw_arbiter_wsched;

    localparam int N  = 8;
    localparam int AW = 64;
    localparam int D  = 4;
`ifdef AW_WSCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    awvalid_i;
    logic [N*AW-1:0] awdata_i;
    logic [N-1:0]    awready_o;
    logic            awvalid_o;
    logic [AW-1:0]   awdata_o;
    logic            awready_i;
    logic [2:0]      wsel_o;
    logic            wsel_valid_o;
    logic            wsel_pop_i;

    logic [AW-1:0]   data [N];
    int              total = 0;
    int              bad   = 0;

    // reference model state
    int              m_rr;
    bit              m_lock;
    int              m_lidx;
    int              q [$];
    // expectations for the current cycle
    bit              e_v;
    bit              e_hs;
    int              e_g;
    logic [N-1:0]    e_rdy;
    bit              e_wv;
    int              e_ws;

    logic [N-1:0]    cur_v;
    logic [AW-1:0]   saved;
    logic [7:0]      one;

    axi_aw_arbiter_wsched dut (
        .clk          (clk),
        .rst          (rst),
        .awvalid_i    (awvalid_i),
        .awdata_i     (awdata_i),
        .awready_o    (awready_o),
        .awvalid_o    (awvalid_o),
        .awdata_o     (awdata_o),
        .awready_i    (awready_i),
        .wsel_o       (wsel_o),
        .wsel_valid_o (wsel_valid_o),
        .wsel_pop_i   (wsel_pop_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: compute the expected outputs from the model and compare them.
    task automatic settle();
        int k;
        for (int j = 0; j < N; j++) awdata_i[j*AW +: AW] = data[j];
        #3;
        e_v = 1'b0; e_hs = 1'b0; e_g = 0; e_rdy = '0; e_wv = 1'b0; e_ws = 0;
        if (!rst) begin
            if (m_lock) begin
                e_g = m_lidx;
                e_v = 1'b1;
            end else begin
                e_g = -1;
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (e_g < 0 && awvalid_i[k]) e_g = k;
                end
                e_v = (e_g >= 0) && (q.size() < D);
                if (e_g < 0) e_g = 0;
            end
            e_hs = e_v && awready_i;
            if (e_hs) e_rdy[e_g] = 1'b1;
            if (q.size() != 0) begin
                e_wv = 1'b1;
                e_ws = q[0];
            end else if (BYP && e_hs) begin
                e_wv = 1'b1;
                e_ws = e_g;
            end
        end
        chk("awvalid_o", awvalid_o, e_v);
        chk("awready_o", awready_o, e_rdy);
        if (e_v) chk("awdata_o", awdata_o, data[e_g]);
        chk("wsel_valid_o", wsel_valid_o, e_wv);
        if (e_wv) chk("wsel_o", wsel_o, e_ws);
    endtask

    // Clock edge: update the model state.
    task automatic advance();
        int sz0;
        @(posedge clk);
        if (rst) begin
            m_rr = 0; m_lock = 1'b0; m_lidx = 0; q.delete();
        end else begin
            sz0 = q.size();
            if (wsel_pop_i && sz0 > 0) void'(q.pop_front());
            if (e_hs) begin
                m_rr   = (e_g + 1) % N;
                m_lock = 1'b0;
                if (!(BYP && sz0 == 0 && wsel_pop_i)) q.push_back(e_g);
            end else if (e_v && !m_lock) begin
                m_lock = 1'b1;
                m_lidx = e_g;
            end
        end
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic drain();
        awvalid_i  = '0;
        wsel_pop_i = 1'b1;
        for (int i = 0; i < D + 2; i++) tick();
    endtask

    initial begin
        for (int j = 0; j < N; j++) data[j] = {$urandom, $urandom};
        m_rr = 0; m_lock = 1'b0; m_lidx = 0;
        rst = 1'b1; awvalid_i = 8'hFF; awready_i = 1'b1; wsel_pop_i = 1'b0;
        for (int j = 0; j < N; j++) awdata_i[j*AW +: AW] = data[j];
        @(posedge clk); #1;

        // 1: reset holds every valid/ready low
        tick();
        settle();
        chk("t1_rst_awvalid", awvalid_o, 1'b0);
        chk("t1_rst_wsel_valid", wsel_valid_o, 1'b0);
        advance();

        // 2: all requesting, slave always ready -> 0..7,0
        rst = 1'b0; wsel_pop_i = 1'b1; one = 8'h01;
        for (int i = 0; i < 9; i++) begin
            settle();
            chk("t2_grant_order", awready_o, one << (i % 8));
            advance();
        end

        // 3: locked grant to port 2 while port 1 joins
        drain();
        awvalid_i = 8'h04; awready_i = 1'b0; saved = data[2];
        tick();
        awvalid_i = 8'h06;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3_hold_data", awdata_o, saved);
            chk("t3_hold_ready", awready_o, 8'h00);
            advance();
        end
        awready_i = 1'b1;
        settle();
        chk("t3_hs", awready_o, 8'h04);
        advance();
        awvalid_i = 8'h02;
        settle();
        chk("t3_next_port1", awready_o, 8'h02);
        advance();

        // 4: fill FIFO from port 5, full blocks the request
        drain();
        wsel_pop_i = 1'b0; awvalid_i = 8'h20;
        for (int i = 0; i < 4; i++) tick();
        settle();
        chk("t4_full_block", awvalid_o, 1'b0);
        advance();
        wsel_pop_i = 1'b1;
        settle();
        chk("t4_pop_no_pass", awvalid_o, 1'b0);
        advance();
        wsel_pop_i = 1'b0;
        settle();
        chk("t4_grant_after_pop", awready_o, 8'h20);
        advance();

        // 5: push+pop at count 2 keeps order; pop at empty ignored
        drain();
        awvalid_i = '0; wsel_pop_i = 1'b1;
        tick();
        wsel_pop_i = 1'b0;
        awvalid_i = 8'h10; tick();
        awvalid_i = 8'h40; tick();
        awvalid_i = 8'h01; wsel_pop_i = 1'b1; tick();
        awvalid_i = '0; wsel_pop_i = 1'b0;
        settle();
        chk("t5_head_after_pp", wsel_o, 3'd6);
        advance();
        wsel_pop_i = 1'b1;
        tick();
        settle();
        chk("t5_last", wsel_o, 3'd0);
        advance();
        settle();
        chk("t5_empty", wsel_valid_o, 1'b0);
        advance();

        // 6: handshake into empty FIFO with pop in the same cycle
        drain();
        awvalid_i = 8'h08; awready_i = 1'b1; wsel_pop_i = 1'b1;
        settle();
        chk("t6_same_cycle_valid", wsel_valid_o, BYP);
        advance();
        awvalid_i = '0; wsel_pop_i = 1'b0;
        settle();
        chk("t6_next_cycle_valid", wsel_valid_o, !BYP);
        advance();

        // randomized phase, requesters obey the AXI hold rule
        drain();
        cur_v = '0;
        for (int c = 0; c < 400; c++) begin
            rst        = (c >= 200 && c < 202);
            awvalid_i  = cur_v;
            awready_i  = 1'($urandom_range(0, 1));
            wsel_pop_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    cur_v[k] = 1'b0;
                end else if (!(cur_v[k] && !(e_hs && e_g == k))) begin
                    cur_v[k] = ($urandom_range(0, 2) == 0);
                    if (cur_v[k]) data[k] = {$urandom, $urandom};
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
